// File: rtl/tlc_pkg.sv
// Shared types for the multi-approach traffic-light controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package tlc_pkg;

  // Encoding is visible on phase_out, so values are fixed.
  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  // One approach's lamp head; exactly one field is set at any time.
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter timing each lamp phase; zero flags the phase's last cycle.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; holds at zero until reloaded.
// Ports: clk, clear_n (sync active-low), load/load_val (reload), zero (count == 0).
module tlc_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_timer <= RST_VAL;
    end else if (load) begin
      r_timer <= load_val;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - CNT_W'(1);
    end
  end

  assign zero = (r_timer == '0);

endmodule

// File: rtl/tlc_multiway.sv
// N-approach traffic-light sequencer: all-red -> green (demand-extended) -> yellow per approach.
// Latency: lamps decode from registered state only; demand acts at the edge ending a phase.
// Backpressure: none; free-running, demand only steers way choice and green extension.
// Ports: clk, clear_n (sync active-low), demand[N_WAYS]; RED/YELLOW/GREEN_out[N_WAYS],
//        phase_out (0=all-red, 1=green, 2=yellow), way_out (active approach).
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int N_WAYS        = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int MAX_EXT       = 4,
  parameter int CNT_W         = 8,
  localparam int WAY_W        = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [N_WAYS-1:0] demand,
  output logic [N_WAYS-1:0] RED_out,
  output logic [N_WAYS-1:0] YELLOW_out,
  output logic [N_WAYS-1:0] GREEN_out,
  output logic [1:0]        phase_out,
  output logic [WAY_W-1:0]  way_out
);

  phase_e             r_phase, w_phase_nxt;
  logic [WAY_W-1:0]   r_way, w_way_nxt;
  logic [CNT_W-1:0]   r_ext, w_ext_nxt;
  logic               w_zero;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  lamp_t              w_lamp;

  // Next approach to serve: rotate demand so cur+1 sits at bit 0, take the
  // lowest set bit, rotate back. cur itself lands at the top bit, so it is
  // checked last. No demand leaves k=0, i.e. plain round-robin.
  function automatic logic [WAY_W-1:0] f_next_way(input logic [N_WAYS-1:0] dem,
                                                  input logic [WAY_W-1:0]  cur);
    logic [2*N_WAYS-1:0] dbl;
    logic [N_WAYS-1:0]   rot;
    int                  base;
    int                  k;
    base = (int'(cur) + 1) % N_WAYS;
    dbl  = {dem, dem} >> base;
    rot  = dbl[N_WAYS-1:0];
    k    = 0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (rot[i]) k = i;
    end
    return WAY_W'((base + k) % N_WAYS);
  endfunction

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALLRED_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_phase <= PH_ALLRED;
      r_way   <= WAY_W'(N_WAYS - 1);
      r_ext   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_way   <= w_way_nxt;
      r_ext   <= w_ext_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_way_nxt   = r_way;
    w_ext_nxt   = r_ext;
    w_load      = 1'b0;
    w_load_val  = '0;
    if (w_zero) begin
      case (r_phase)
        PH_ALLRED: begin
          w_phase_nxt = PH_GREEN;
          w_way_nxt   = f_next_way(demand, r_way);
          w_ext_nxt   = '0;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(GREEN_CYCLES - 1);
        end
        PH_GREEN: begin
          // Extension leaves the timer parked at zero so the same
          // decision is re-evaluated on each extra cycle.
          if (demand[r_way] && (r_ext < CNT_W'(MAX_EXT))) begin
            w_ext_nxt = r_ext + CNT_W'(1);
          end else begin
            w_phase_nxt = PH_YELLOW;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(YELLOW_CYCLES - 1);
          end
        end
        default: begin
          // Yellow, and recovery from the unused encoding.
          w_phase_nxt = PH_ALLRED;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(ALLRED_CYCLES - 1);
        end
      endcase
    end
  end

  always_comb begin
    RED_out    = '0;
    YELLOW_out = '0;
    GREEN_out  = '0;
    w_lamp     = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    for (int i = 0; i < N_WAYS; i++) begin
      w_lamp = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
      if (WAY_W'(i) == r_way) begin
        if (r_phase == PH_GREEN)  w_lamp = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
        if (r_phase == PH_YELLOW) w_lamp = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
      end
      RED_out[i]    = w_lamp.red;
      YELLOW_out[i] = w_lamp.yellow;
      GREEN_out[i]  = w_lamp.green;
    end
  end

  assign phase_out = r_phase;
  assign way_out   = r_way;

endmodule
